switch_port_arbiter: RTL and testbench
======================================

Name: switch_port_arbiter

Overview:
- Control block for the 4-port switch datapath.
- Each input port carries an 8-bit data lane and an 8-bit destination-address lane, plus a valid bit.
- Decodes each input's destination address to an output port and grants each output to one input at a time, using per-output round-robin arbitration.
- Holds the grant for the whole packet (valid high) and drives the per-input rcv_rdy handshake that the datapath mux and the sources consume.

Parameters:
- PORT0_ADDR, 8'h00, destination address code of output port 0
- PORT1_ADDR, 8'h01, destination address code of output port 1
- PORT2_ADDR, 8'h02, destination address code of output port 2
- PORT3_ADDR, 8'h03, destination address code of output port 3
- MAX_PKT_LEN, 64, max grant length in cycles (used only with ARB_TIMEOUT_EN)

Ports:
- clk  input  1  system clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- valid_in  input  4  valid_in[i]: input i presents a packet word
- addr_in  input  32  addr_in[8*i+:8]: destination address of input i
- data_rd  input  4  data_rd[o]: receiver on output o can accept a word
- rcv_rdy  output  4  rcv_rdy[i]: input i owns an output and may advance
- grant  output  16  grant[4*o+i]: input i owns output o; one-hot or zero per o
- out_busy  output  4  output o currently granted
- err_addr  output  4  one-cycle pulse: input i packet start with undecodable address
- timeout  output  4  one-cycle pulse: output o grant force-released

Behaviour:
- Synchronous, active-high reset. At the next edge with reset=1, all outputs are cleared:
  - rcv_rdy=0, grant=0, out_busy=0, err_addr=0, timeout=0
  - all output FSMs go to IDLE
  - all RR pointers go to 0
  - reset mid-packet drops the grant at that edge.
- Decode: input i targets output o when addr_in[8*i+:8]==PORTo_ADDR. If no port matches, the address is undecodable. If several parameters are equal, the lowest o wins.
- Request: req[o][i] = valid_in[i] & targets(i,o) & input i not granted & input i not in its post-packet lockout.
- Per-output FSM has three states:
  - IDLE:
    - if any req[o], pick the winner by round robin starting at ptr[o]
    - register grant[4*o+win]=1 and out_busy[o]=1
    - ptr[o] <= win+1 mod 4
    - go to BUSY
  - BUSY:
    - hold the grant while valid_in[win]=1
    - when valid_in[win]=0, clear the grant and out_busy, go to RELEASE
  - RELEASE: one idle cycle (bus turnaround), then IDLE. No new grant is issued for o in this cycle.
- Latency:
  - valid_in rises in cycle N with the output idle → grant and rcv_rdy high in N+1.
  - valid drops in cycle M → grant low in M+1.
  - earliest next grant on the same output is in M+3.
- rcv_rdy[i] = (input i granted on output o) & data_rd[o]. It is combinational from the registered grant. A source advances a word only in cycles with valid_in[i]&rcv_rdy[i].
- Wrap-around: the round-robin search order is ptr, ptr+1, ... mod 4.
- Simultaneous events:
  - different outputs arbitrate independently in the same cycle
  - an input has one destination, so it is never granted two outputs
  - a requester arriving during BUSY or RELEASE waits; there is no starvation (RR)
- Destination changes are not allowed mid-packet: addr_in is sampled only at grant time and ignored while BUSY.
- Undecodable address:
  - err_addr[i] pulses for one cycle on the first cycle of valid_in[i]
  - input i is never granted, so rcv_rdy[i] stays 0
  - no further pulse until valid_in[i] has been low for ≥1 cycle
- Lockout: after release, input i is not requestable until valid_in[i] has been seen low, which prevents an immediate re-grant of a stale valid.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - a per-output counter counts BUSY cycles
  - on reaching MAX_PKT_LEN, the FSM force-releases to RELEASE and pulses timeout[o] for 1 cycle
  - input i enters lockout until its valid drops
- Undefined: no counters; grants are unbounded; timeout is tied to 4'b0000.

Test Plan:
- Reset then idle → all outputs 0; assert reset during a BUSY grant → grant=0 at the next edge, and the RR ptr restarts at 0 (input 0 wins the next contention).
- Input 2 valid, addr 8'h01, data_rd=4'hF, 5-cycle packet → grant[6]=1 from N+1 to N+5, rcv_rdy=4'b0100, release at N+6, out_busy[1] low for the RELEASE cycle.
- Inputs 0, 1, 3 all target 8'h03, packets re-asserted continuously → grant order on output 3 is in0, in1, in3, in0, each separated by 1 RELEASE cycle.
- Inputs 0→8'h00 and 1→8'h02 simultaneously → both granted the same cycle; grant=16'h0201.
- Input 3 addr 8'h7F valid for 4 cycles → err_addr=4'b1000 for exactly 1 cycle; rcv_rdy[3]=0 throughout.
- ARB_TIMEOUT_EN, MAX_PKT_LEN=8, input 0→8'h00 valid held 20 cycles → timeout[0] pulses at BUSY cycle 8; no re-grant of input 0 until valid drops (then output 0 serves other requesters).

Source files
------------

// File: rtl/switch_port_arbiter.sv
// switch_port_arbiter
//
// Control block for the 4-port switch datapath. Each input port presents a
// valid bit and an 8-bit destination address. The address is decoded to an
// output port, and each output is granted to one input at a time. Arbitration
// is round robin per output. A grant is held for the whole packet (while the
// owner keeps valid high). After each packet, the output spends one turnaround
// cycle before it can grant again.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   - Each output counts its BUSY cycles.
//   - After MAX_PKT_LEN cycles the grant is force-released and timeout[o]
//     pulses.
//   - Without the macro, grants are unbounded and timeout is tied low.
//
// Ports:
//   clk       system clock, all logic on posedge
//   reset     synchronous, active-high reset
//   valid_in  [3:0]  input i presents a packet word
//   addr_in   [31:0] addr_in[8*i+:8] is the destination address of input i
//   data_rd   [3:0]  receiver on output o can accept a word
//   rcv_rdy   [3:0]  input i owns an output whose receiver is ready
//   grant     [15:0] grant[4*o+i]: input i owns output o (one-hot or zero per o)
//   out_busy  [3:0]  output o currently granted
//   err_addr  [3:0]  one-cycle pulse: packet start with undecodable address
//   timeout   [3:0]  one-cycle pulse: output o grant force-released
module switch_port_arbiter #(
  parameter logic [7:0] PORT0_ADDR  = 8'h00,
  parameter logic [7:0] PORT1_ADDR  = 8'h01,
  parameter logic [7:0] PORT2_ADDR  = 8'h02,
  parameter logic [7:0] PORT3_ADDR  = 8'h03,
  parameter int         MAX_PKT_LEN = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  valid_in,
  input  logic [31:0] addr_in,
  input  logic [3:0]  data_rd,
  output logic [3:0]  rcv_rdy,
  output logic [15:0] grant,
  output logic [3:0]  out_busy,
  output logic [3:0]  err_addr,
  output logic [3:0]  timeout
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  // A zero or negative grant length would make the timeout counter meaningless.
  if (MAX_PKT_LEN < 1) begin : g_bad_max_pkt_len
    $error("MAX_PKT_LEN must be at least 1");
  end

  state_t     state [4];
  logic [1:0] owner [4];
  logic [1:0] ptr   [4];
  logic [1:0] win   [4];
  logic [1:0] target [4];
  logic [3:0] req   [4];

  logic [3:0] dec_ok;
  logic [3:0] in_granted;
  logic [3:0] any_req;
  logic [3:0] pkt_end;
  logic [3:0] free_o;
  logic [3:0] releasing;
  logic [3:0] lockout;
  logic [3:0] valid_q;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PKT_LEN - 1);
  logic [CNT_W-1:0] cnt [4];
  logic [3:0]       hit;
`endif

  function automatic logic [7:0] port_addr(input int o);
    case (o)
      0:       return PORT0_ADDR;
      1:       return PORT1_ADDR;
      2:       return PORT2_ADDR;
      default: return PORT3_ADDR;
    endcase
  endfunction

  // Address decode. The scan runs from high to low so that, when several
  // port addresses are equal, the lowest output index is the one kept.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      dec_ok[i] = 1'b0;
      target[i] = 2'd0;
      for (int o = 3; o >= 0; o--) begin
        if (addr_in[8*i +: 8] == port_addr(o)) begin
          dec_ok[i] = 1'b1;
          target[i] = 2'(o);
        end
      end
      in_granted[i] = grant[i] | grant[4+i] | grant[8+i] | grant[12+i];
    end
  end

  // Per-output request vectors and round-robin winner.
  // The search for output o starts at ptr[o] and wraps modulo 4.
  always_comb begin : rr_pick
    logic       found;
    logic [1:0] idx;
    for (int o = 0; o < 4; o++) begin
      req[o] = '0;
      for (int i = 0; i < 4; i++) begin
        req[o][i] = valid_in[i] & dec_ok[i] & (target[i] == 2'(o)) &
                    ~in_granted[i] & ~lockout[i];
      end
      any_req[o] = |req[o];
      win[o]     = ptr[o];
      found      = 1'b0;
      for (int k = 0; k < 4; k++) begin
        idx = ptr[o] + 2'(k);
        if (!found && req[o][idx]) begin
          win[o] = idx;
          found  = 1'b1;
        end
      end
    end
  end

  // Release detection.
  //   - A packet ends normally when the owner drops valid.
  //   - With the timeout feature, a grant is also freed when its BUSY count
  //     reaches its limit.
  //   - releasing[] marks inputs losing their grant this cycle. If such an
  //     input still holds valid, it has to go low before it may request again.
  always_comb begin
    releasing = '0;
    for (int o = 0; o < 4; o++) begin
      pkt_end[o] = (state[o] == BUSY) & ~valid_in[owner[o]];
`ifdef ARB_TIMEOUT_EN
      hit[o]     = (state[o] == BUSY) & valid_in[owner[o]] & (cnt[o] == CNT_LAST);
      free_o[o]  = pkt_end[o] | hit[o];
`else
      free_o[o]  = pkt_end[o];
`endif
      if (free_o[o]) begin
        releasing[owner[o]] = 1'b1;
      end
    end
  end

  // The source handshake follows the registered grant, gated by the
  // receiver readiness of whichever output the input owns.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rcv_rdy[i] = 1'b0;
      for (int o = 0; o < 4; o++) begin
        rcv_rdy[i] = rcv_rdy[i] | (grant[4*o+i] & data_rd[o]);
      end
    end
  end

  // Per-output FSMs, plus the per-input error-pulse and lockout state.
  //   - err_addr fires only on the rising edge of valid, so a long bad
  //     packet reports once.
  //   - Lockout clears as soon as valid is observed low.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant    <= '0;
      out_busy <= '0;
      err_addr <= '0;
      lockout  <= '0;
      valid_q  <= '0;
      for (int o = 0; o < 4; o++) begin
        state[o] <= IDLE;
        owner[o] <= 2'd0;
        ptr[o]   <= 2'd0;
`ifdef ARB_TIMEOUT_EN
        cnt[o]   <= '0;
`endif
      end
`ifdef ARB_TIMEOUT_EN
      timeout  <= '0;
`endif
    end else begin
      err_addr <= valid_in & ~valid_q & ~dec_ok;
      valid_q  <= valid_in;
      lockout  <= valid_in & (lockout | releasing);
`ifdef ARB_TIMEOUT_EN
      timeout  <= hit;
`endif
      for (int o = 0; o < 4; o++) begin
        case (state[o])
          IDLE: begin
            if (any_req[o]) begin
              grant[4*o + int'(win[o])] <= 1'b1;
              out_busy[o] <= 1'b1;
              owner[o]    <= win[o];
              ptr[o]      <= win[o] + 2'd1;
              state[o]    <= BUSY;
`ifdef ARB_TIMEOUT_EN
              cnt[o]      <= '0;
`endif
            end
          end
          BUSY: begin
            if (free_o[o]) begin
              grant[4*o +: 4] <= 4'b0000;
              out_busy[o]     <= 1'b0;
              state[o]        <= RELEASE;
            end
`ifdef ARB_TIMEOUT_EN
            else begin
              cnt[o] <= cnt[o] + 1'b1;
            end
`endif
          end
          RELEASE: begin
            state[o] <= IDLE;
          end
          default: begin
            state[o] <= IDLE;
          end
        endcase
      end
    end
  end

`ifndef ARB_TIMEOUT_EN
  assign timeout = 4'b0000;
`endif

endmodule

// File: tb/tb_switch_port_arbiter.sv
// Testbench for switch_port_arbiter (default build, default port addresses).
//
// Stimulus is driven on the falling edge. Each drive step also advances a
// behavioural model of the arbiter, which is written in terms of packet
// ownership. The model pushes the expected post-edge outputs into a
// scoreboard queue. A monitor process pops one entry after every rising edge
// and compares it with the DUT outputs.
module tb_switch_port_arbiter;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic [3:0]  valid_in = '0;
  logic [31:0] addr_in  = '0;
  logic [3:0]  data_rd  = '0;
  logic [3:0]  rcv_rdy;
  logic [15:0] grant;
  logic [3:0]  out_busy;
  logic [3:0]  err_addr;
  logic [3:0]  timeout;

  typedef struct packed {
    logic [15:0] grant;
    logic [3:0]  busy;
    logic [3:0]  err;
    logic [3:0]  tmo;
    logic [3:0]  rcv;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Model state:
  //   m_owner  which input owns each output (-1 when free)
  //   m_gap    output is in its turnaround cycle
  //   m_rr     round-robin start for each output
  //   m_lock   input needs valid low before it may request again
  //   m_pv     valid seen in the previous cycle
  int m_owner [4];
  bit m_gap   [4];
  int m_rr    [4];
  bit m_lock  [4];
  bit m_pv    [4];

  always #5 clk = ~clk;

  switch_port_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .valid_in (valid_in),
    .addr_in  (addr_in),
    .data_rd  (data_rd),
    .rcv_rdy  (rcv_rdy),
    .grant    (grant),
    .out_busy (out_busy),
    .err_addr (err_addr),
    .timeout  (timeout)
  );

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of the behavioural model, using the inputs presented this cycle.
  task automatic modelStep(input logic rst, input logic [3:0] v, input logic [31:0] a,
                           input logic [3:0] drd);
    exp_t e;
    int   dest [4];
    bit   held [4];
    bit   rel  [4];
    bit   found;
    int   cand;
    int   av;
    e = '0;
    if (rst) begin
      for (int o = 0; o < 4; o++) begin
        m_owner[o] = -1;
        m_gap[o]   = 1'b0;
        m_rr[o]    = 0;
      end
      for (int i = 0; i < 4; i++) begin
        m_lock[i] = 1'b0;
        m_pv[i]   = 1'b0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        av      = int'(a[8*i +: 8]);
        dest[i] = (av < 4) ? av : -1;
        held[i] = 1'b0;
        rel[i]  = 1'b0;
      end
      for (int o = 0; o < 4; o++) begin
        if (m_owner[o] >= 0) held[m_owner[o]] = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
        e.err[i] = v[i] && !m_pv[i] && (dest[i] < 0);
      end
      for (int o = 0; o < 4; o++) begin
        if (m_owner[o] >= 0) begin
          if (!v[m_owner[o]]) begin
            rel[m_owner[o]] = 1'b1;
            m_owner[o] = -1;
            m_gap[o]   = 1'b1;
          end
        end else if (m_gap[o]) begin
          m_gap[o] = 1'b0;
        end else begin
          found = 1'b0;
          for (int k = 0; k < 4; k++) begin
            cand = (m_rr[o] + k) % 4;
            if (!found && v[cand] && dest[cand] == o && !held[cand] && !m_lock[cand]) begin
              m_owner[o] = cand;
              m_rr[o]    = (cand + 1) % 4;
              found      = 1'b1;
            end
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        m_lock[i] = v[i] && (m_lock[i] || rel[i]);
        m_pv[i]   = v[i];
      end
    end
    for (int o = 0; o < 4; o++) begin
      if (m_owner[o] >= 0) begin
        e.grant[4*o + m_owner[o]] = 1'b1;
        e.busy[o] = 1'b1;
        if (drd[o]) e.rcv[m_owner[o]] = 1'b1;
      end
    end
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs and advance the model.
  // xfer reports which inputs move a word at the coming edge, according to
  // the model's current grants.
  task automatic applyStimulus(input logic rst, input logic [3:0] v, input logic [31:0] a,
                               input logic [3:0] drd, output logic [3:0] xfer);
    @(negedge clk);
    reset    = rst;
    valid_in = v;
    addr_in  = a;
    data_rd  = drd;
    xfer     = '0;
    if (!rst) begin
      for (int o = 0; o < 4; o++) begin
        if (m_owner[o] >= 0 && drd[o] && v[m_owner[o]]) xfer[m_owner[o]] = 1'b1;
      end
    end
    modelStep(rst, v, a, drd);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("grant",    grant,          e.grant);
        checkOutput("out_busy", 16'(out_busy), 16'(e.busy));
        checkOutput("err_addr", 16'(err_addr), 16'(e.err));
        checkOutput("timeout",  16'(timeout),  16'(e.tmo));
        checkOutput("rcv_rdy",  16'(rcv_rdy),  16'(e.rcv));
      end
    end
  end

  initial begin : stimulus
    logic [3:0]  x;
    logic [3:0]  v;
    logic [3:0]  drd;
    logic [31:0] a_cur;
    logic        rst;
    int          hold [4];
    bit          drop [4];
    logic [3:0]  prev_nib;
    logic [3:0]  order [$];
    logic [3:0]  rr_exp [4];
    int          left [4];
    int          gap  [4];
    bit          bad  [4];

    // Reset, then idle.
    repeat (2) applyStimulus(1'b1, 4'b0000, 32'h0, 4'hF, x);
    repeat (2) applyStimulus(1'b0, 4'b0000, 32'h0, 4'hF, x);

    // Single 5-cycle packet: input 2 to output 1.
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 4'b0100, {8'h00, 8'h01, 8'h00, 8'h00}, 4'hF, x);
      if (c == 0) begin
        @(posedge clk);
        #2;
        checkOutput("pkt_grant", grant, 16'h0040);
        checkOutput("pkt_rcv", 16'(rcv_rdy), 16'h0004);
      end
    end
    repeat (3) applyStimulus(1'b0, 4'b0000, 32'h0, 4'hF, x);

    // Two inputs to two different outputs in the same cycle.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 4'b0011, {8'h00, 8'h00, 8'h02, 8'h00}, 4'hF, x);
      if (c == 0) begin
        @(posedge clk);
        #2;
        checkOutput("simul_grant", grant, 16'h0201);
      end
    end
    repeat (3) applyStimulus(1'b0, 4'b0000, 32'h0, 4'hF, x);

    // Undecodable address held for 4 cycles.
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 4'b1000, {8'h7F, 8'h00, 8'h00, 8'h00}, 4'hF, x);
      if (c == 0) begin
        @(posedge clk);
        #2;
        checkOutput("bad_err", 16'(err_addr), 16'h0008);
      end
    end
    repeat (2) applyStimulus(1'b0, 4'b0000, 32'h0, 4'hF, x);

    // Reset during a grant.
    //   - Output 1 is granted to input 2, which moves its pointer to 3.
    //   - After reset, inputs 1 and 3 contend for output 1.
    //   - Input 1 must win, because the pointer restarted at 0.
    repeat (3) applyStimulus(1'b0, 4'b0100, {8'h00, 8'h01, 8'h00, 8'h00}, 4'hF, x);
    applyStimulus(1'b1, 4'b0100, {8'h00, 8'h01, 8'h00, 8'h00}, 4'hF, x);
    @(posedge clk);
    #2;
    checkOutput("rst_grant", grant, 16'h0000);
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b0, 4'b1010, {8'h01, 8'h00, 8'h01, 8'h00}, 4'hF, x);
      if (c == 0) begin
        @(posedge clk);
        #2;
        checkOutput("rst_rr_grant", grant, 16'h0020);
      end
    end
    repeat (4) applyStimulus(1'b0, 4'b0000, 32'h0, 4'hF, x);

    // Round robin on output 3.
    //   - Inputs 0, 1 and 3 keep re-requesting.
    //   - Each owner holds the grant for two cycles, then drops valid for one.
    for (int i = 0; i < 4; i++) begin
      hold[i] = 0;
      drop[i] = 1'b0;
    end
    prev_nib = 4'h0;
    for (int c = 0; c < 24; c++) begin
      v = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        if (i != 2) begin
          if (drop[i]) begin
            drop[i] = 1'b0;
            hold[i] = 0;
          end else begin
            v[i] = 1'b1;
          end
        end
      end
      applyStimulus(1'b0, v, 32'h03030303, 4'hF, x);
      for (int i = 0; i < 4; i++) begin
        if (m_owner[3] == i) begin
          hold[i]++;
          if (hold[i] == 2) drop[i] = 1'b1;
        end
      end
      @(posedge clk);
      #2;
      if (grant[15:12] != 4'h0 && prev_nib == 4'h0) order.push_back(grant[15:12]);
      prev_nib = grant[15:12];
    end
    rr_exp = '{4'h1, 4'h2, 4'h8, 4'h1};
    checkOutput("rr_count", 16'(order.size() >= 4), 16'h0001);
    for (int k = 0; k < 4; k++) begin
      if (k < order.size()) checkOutput("rr_order", 16'(order[k]), 16'(rr_exp[k]));
    end
    repeat (4) applyStimulus(1'b0, 4'b0000, 32'h0, 4'hF, x);

    // Randomised traffic.
    //   - Sources send 1..6 words, advancing only when granted and ready.
    //   - Occasionally a source presents an undecodable address for a few
    //     cycles.
    //   - Rare resets are injected.
    a_cur = '0;
    for (int i = 0; i < 4; i++) begin
      left[i] = 0;
      gap[i]  = 0;
      bad[i]  = 1'b0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 499) == 0);
      v   = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        if (left[i] > 0) begin
          v[i] = 1'b1;
        end else if (gap[i] > 0) begin
          gap[i]--;
        end else if ($urandom_range(0, 2) == 0) begin
          bad[i] = ($urandom_range(0, 7) == 0);
          a_cur[8*i +: 8] = bad[i] ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
          left[i] = bad[i] ? int'($urandom_range(1, 4)) : int'($urandom_range(1, 6));
          v[i] = 1'b1;
        end
      end
      drd = 4'($urandom) | 4'($urandom);
      applyStimulus(rst, v, a_cur, drd, x);
      for (int i = 0; i < 4; i++) begin
        if (left[i] > 0 && (bad[i] || x[i])) begin
          left[i]--;
          if (left[i] == 0) gap[i] = int'($urandom_range(1, 3));
        end
      end
    end

    repeat (3) applyStimulus(1'b0, 4'b0000, 32'h0, 4'hF, x);
    @(posedge clk);
    #3;
    checkOutput("sb_drained", 16'(sb.size()), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
